// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - shared types for the kronos memory arbiter
//
// Contents:
//   mem_owner_e : owner of the shared memory port (none, fetch, load/store)
//   memreq_t    : one memory request {addr, wdata, mask, wr}
//   sat_inc4    : 4-bit saturating increment used by the starvation counter

package kronos_types;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } mem_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
  } memreq_t;

  localparam logic [3:0] STARVE_CNT_MAX = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == STARVE_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/kronos_mem_arbiter.sv
// rtl/kronos_mem_arbiter.sv - shares one single-port 32b memory between fetch and load/store
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_addr/instr_req          fetch request from IF
//   instr_gnt/instr_data          fetch completion and read data
//   data_addr/wdata/mask/wr/req   load/store request from LSU
//   data_gnt/data_rdata           load/store completion and load data
//   mem_addr/wdata/mask/wr/req    request presented to the memory
//   mem_gnt/mem_rdata             memory completion and read data
//
// Data has fixed priority; after STARVE_LIMIT consecutive data grants with a
// fetch waiting, the fetch wins one turn. A request that misses (req without
// gnt) locks the port to its owner until the memory grants it.

module kronos_mem_arbiter
  import kronos_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  input  logic        data_wr,
  input  logic        data_req,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_wr,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

  mem_owner_e lock_q;
  logic [3:0] starve_cnt_q;

  mem_owner_e owner;
  memreq_t    if_rq;
  memreq_t    data_rq;
  memreq_t    sel_rq;
  logic       sel_req;

  // Fetch never writes, so its write fields are tied off.
  always_comb begin
    if_rq         = '0;
    if_rq.addr    = instr_addr;
    data_rq       = '0;
    data_rq.addr  = data_addr;
    data_rq.wdata = data_wdata;
    data_rq.mask  = data_mask;
    data_rq.wr    = data_wr;
  end

  // Effective owner: the locked owner wins outright; otherwise arbitrate
  // combinationally so a fresh request reaches memory in the same cycle.
  always_comb begin
    owner = OWN_NONE;
    if (lock_q != OWN_NONE) begin
      owner = lock_q;
    end else if (data_req && instr_req) begin
      owner = (starve_cnt_q >= STARVE_LIMIT_C) ? OWN_IF : OWN_DATA;
    end else if (data_req) begin
      owner = OWN_DATA;
    end else if (instr_req) begin
      owner = OWN_IF;
    end
  end

  always_comb begin
    sel_rq  = '0;
    sel_req = 1'b0;
    case (owner)
      OWN_IF: begin
        sel_rq  = if_rq;
        sel_req = instr_req;
      end
      OWN_DATA: begin
        sel_rq  = data_rq;
        sel_req = data_req;
      end
      default: begin
        sel_rq  = '0;
        sel_req = 1'b0;
      end
    endcase
  end

  // mem_wr is qualified by mem_req so a dropped store never leaves a write
  // strobe on the bus.
  always_comb begin
    mem_addr   = sel_rq.addr;
    mem_wdata  = sel_rq.wdata;
    mem_mask   = sel_rq.mask;
    mem_wr     = sel_rq.wr & sel_req;
    mem_req    = sel_req;
    instr_gnt  = mem_gnt & (owner == OWN_IF);
    data_gnt   = mem_gnt & (owner == OWN_DATA);
    instr_data = mem_rdata;
    data_rdata = mem_rdata;
  end

  // A miss keeps the owner; a grant or a dropped request frees the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= OWN_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      if (mem_req && !mem_gnt) begin
        lock_q <= owner;
      end else begin
        lock_q <= OWN_NONE;
      end

      if (data_gnt) begin
        starve_cnt_q <= instr_req ? sat_inc4(starve_cnt_q) : 4'd0;
      end else if (instr_gnt) begin
        starve_cnt_q <= 4'd0;
      end
    end
  end

  a_if_holds_req: assert property (@(posedge clk) disable iff (rst)
    (lock_q == OWN_IF) |-> instr_req);

  a_data_holds_req: assert property (@(posedge clk) disable iff (rst)
    (lock_q == OWN_DATA) |-> data_req);

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// tb/tb_kronos_mem_arbiter.sv - directed self-checking bench for kronos_mem_arbiter

module tb_kronos_mem_arbiter;
  import kronos_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_data;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_wr;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        gate;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  kronos_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_gnt(instr_gnt), .instr_data(instr_data),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_mask(data_mask),
    .data_wr(data_wr), .data_req(data_req),
    .data_gnt(data_gnt), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr(mem_wr), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  // Single-port memory: same-cycle response, gnt withheld while gate=0.
  assign mem_gnt   = mem_req & gate;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && mem_gnt && mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req  = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_mask  = 4'h0;
    data_wdata = 32'h0;
  endtask

  int          pc;
  int          fetches;
  int          stores;
  int          stall_left;
  int          cyc;
  logic        prev_stalled;
  logic [31:0] prev_addr;
  logic        prev_wr;
  logic [31:0] wd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      exp_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    rst = 1'b1; gate = 1'b1;
    instr_addr = 32'h0; data_addr = 32'h0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state with no requests
    @(negedge clk);
    check_eq("rst_mem_req",   32'(mem_req),   32'd0);
    check_eq("rst_mem_wr",    32'(mem_wr),    32'd0);
    check_eq("rst_instr_gnt", 32'(instr_gnt), 32'd0);
    check_eq("rst_data_gnt",  32'(data_gnt),  32'd0);
    check_eq("rst_mem_addr",  mem_addr,       32'd0);
    check_eq("rst_mem_wdata", mem_wdata,      32'd0);
    check_eq("rst_mem_mask",  32'(mem_mask),  32'd0);
    check_eq("rst_lock",      32'(dut.lock_q), 32'(OWN_NONE));
    check_eq("rst_cnt",       32'(dut.starve_cnt_q), 32'd0);
    next_cycle();

    // IF only: a fetch granted every cycle, in order
    pc = 0;
    instr_req = 1'b1;
    for (int k = 0; k < 128; k++) begin
      instr_addr = pc;
      @(negedge clk);
      check_eq("if_gnt",      32'(instr_gnt), 32'd1);
      check_eq("if_data_gnt", 32'(data_gnt),  32'd0);
      check_eq("if_mem_wr",   32'(mem_wr),    32'd0);
      check_eq("if_data",     instr_data,     exp_mem[pc[9:2]]);
      next_cycle();
      pc += 4;
    end
    instr_req = 1'b0;
    next_cycle();

    // Contention with counter at 0: data first, fetch on the next grant
    instr_req = 1'b1; instr_addr = 32'h100;
    data_req  = 1'b1; data_addr  = 32'h40; data_wr = 1'b0;
    @(negedge clk);
    check_eq("cont_data_gnt",  32'(data_gnt),  32'd1);
    check_eq("cont_instr_gnt", 32'(instr_gnt), 32'd0);
    check_eq("cont_rdata",     data_rdata,     exp_mem[8'h10]);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    check_eq("cont_instr_gnt2", 32'(instr_gnt), 32'd1);
    check_eq("cont_instr_data", instr_data,     exp_mem[8'h40]);
    next_cycle();
    instr_req = 1'b0;
    next_cycle();

    // Starvation: 4 data grants, then one fetch, repeating
    pc = 0;
    instr_req = 1'b1; instr_addr = 32'h0;
    data_req  = 1'b1; data_addr  = 32'h40;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check_eq("starve_cnt",       32'(dut.starve_cnt_q), 32'(k % 5));
      check_eq("starve_data_gnt",  32'(data_gnt),  32'((k % 5) != 4));
      check_eq("starve_instr_gnt", 32'(instr_gnt), 32'((k % 5) == 4));
      if ((k % 5) == 4) check_eq("starve_idata", instr_data, exp_mem[pc[9:2]]);
      else              check_eq("starve_drdata", data_rdata, exp_mem[8'h10]);
      next_cycle();
      if ((k % 5) == 4) begin
        pc += 4;
        instr_addr = pc;
      end
    end
    @(negedge clk);
    check_eq("starve_cnt_end", 32'(dut.starve_cnt_q), 32'd0);
    idle_inputs();
    next_cycle();

    // Store, read it back, then confirm a fetch carries no write
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80;
    data_wdata = 32'hDEAD_BEEF; data_mask = 4'hF;
    @(negedge clk);
    check_eq("st_data_gnt", 32'(data_gnt),  32'd1);
    check_eq("st_mem_wr",   32'(mem_wr),    32'd1);
    check_eq("st_mem_mask", 32'(mem_mask),  32'hF);
    check_eq("st_mem_wdata", mem_wdata,     32'hDEAD_BEEF);
    next_cycle();
    exp_mem[8'h20] = 32'hDEAD_BEEF;
    data_wr = 1'b0;
    @(negedge clk);
    check_eq("st_readback", data_rdata, 32'hDEAD_BEEF);
    check_eq("st_mem_wr_ld", 32'(mem_wr), 32'd0);
    next_cycle();
    idle_inputs();
    instr_req = 1'b1; instr_addr = 32'h80;
    @(negedge clk);
    check_eq("st_if_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("st_if_data",   instr_data,  32'hDEAD_BEEF);
    next_cycle();
    instr_req = 1'b0;
    next_cycle();

    // Misses: random gnt stalls with both requesters active
    pc = 0; fetches = 0; stores = 0; stall_left = 0; cyc = 0;
    prev_stalled = 1'b0; prev_addr = 32'h0; prev_wr = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h0;
    wd = $urandom;
    data_req = 1'b1; data_wr = 1'b1; data_mask = 4'b0101;
    data_addr = 32'h200; data_wdata = wd;
    while ((fetches < 128 || stores < 64) && cyc < 3000) begin
      if (stall_left > 0) begin
        gate = 1'b0;
        stall_left--;
      end else begin
        gate = 1'b1;
        if ($urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 4);
      end
      @(negedge clk);
      if (prev_stalled) begin
        check_eq("miss_addr_stable",  mem_addr,     prev_addr);
        check_eq("miss_owner_stable", 32'(mem_wr),  32'(prev_wr));
        check_eq("miss_req_held",     32'(mem_req), 32'd1);
      end
      if (instr_gnt && data_gnt) check_eq("miss_both_gnt", 32'd1, 32'd0);
      if (instr_gnt) check_eq("miss_idata", instr_data, exp_mem[pc[9:2]]);
      prev_stalled = mem_req & ~mem_gnt;
      prev_addr    = mem_addr;
      prev_wr      = mem_wr;
      next_cycle();
      cyc++;
      if (instr_gnt === 1'b0 && data_gnt === 1'b0) begin
      end
      if (prev_stalled == 1'b0 && mem_req == 1'b0) begin
      end
      if (!prev_stalled && prev_addr == instr_addr && !prev_wr && instr_req) begin
        fetches++;
        pc += 4;
        instr_addr = pc;
        if (fetches == 128) instr_req = 1'b0;
      end else if (!prev_stalled && prev_wr && data_req) begin
        exp_mem[data_addr[9:2]] = (exp_mem[data_addr[9:2]] & 32'hFF00_FF00)
                                | (wd & 32'h00FF_00FF);
        stores++;
        if (stores == 64) begin
          data_req = 1'b0;
          data_wr  = 1'b0;
        end else begin
          wd = $urandom;
          data_addr  = 32'h200 + 32'(stores * 4);
          data_wdata = wd;
        end
      end
    end
    check_eq("miss_fetch_count", 32'(fetches), 32'd128);
    check_eq("miss_store_count", 32'(stores),  32'd64);
    gate = 1'b1;
    idle_inputs();
    next_cycle();
    for (int j = 0; j < 64; j++) begin
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200 + 32'(j * 4);
      @(negedge clk);
      check_eq("miss_rb_gnt",   32'(data_gnt), 32'd1);
      check_eq("miss_rb_rdata", data_rdata,    exp_mem[data_addr[9:2]]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Reset while DATA is locked with the grant withheld
    instr_req = 1'b1; instr_addr = 32'h10;
    data_req  = 1'b1; data_addr  = 32'h40; data_wr = 1'b0;
    next_cycle();
    next_cycle();
    gate = 1'b0;
    @(negedge clk);
    check_eq("rm_sel_addr", mem_addr, 32'h40);
    next_cycle();
    @(negedge clk);
    check_eq("rm_lock_data", 32'(dut.lock_q),       32'(OWN_DATA));
    check_eq("rm_cnt_pre",   32'(dut.starve_cnt_q), 32'd2);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; gate = 1'b1;
    @(negedge clk);
    check_eq("rm_lock_none", 32'(dut.lock_q),       32'(OWN_NONE));
    check_eq("rm_cnt_zero",  32'(dut.starve_cnt_q), 32'd0);
    check_eq("rm_data_gnt",  32'(data_gnt),  32'd1);
    check_eq("rm_rdata",     data_rdata,     exp_mem[8'h10]);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    check_eq("rm_instr_gnt", 32'(instr_gnt), 32'd1);
    check_eq("rm_idata",     instr_data,     exp_mem[8'h04]);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
